xor_env_mealy_driver: RTL and testbench

Synchronous environment driver for the xor-gate Mealy MSFSM network (`fsm_mealy_behav_01/02/03`). It accepts operand pairs from an upstream handshake and drives the dual-rail inputs `a_P_/a_M_/b_P_/b_M_` as levels. It then waits for the single-cycle `e_out_P`/`e_out_M` pulse, returns all rails to zero for a spacer period, and reports the result downstream. It is the initiator end of the network's input/output protocol, used both as a bench stimulus source and as the on-chip front end.

---
 rtl/xor_env_mealy_driver.sv | 128 ++++++++++++
 tb/tb_xor_env_mealy_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xor_env_mealy_driver.sv
// Initiator for the dual-rail xor Mealy network: drives operand rails, waits for the
// e_out pulse, holds a spacer, then offers the result. Define XOR_ENV_CHECK_EN for the result checker.
//
// state    | meaning
// IDLE     | ready for an operand pair; all rails 0
// WAIT_OUT | rails driven, waiting for e_out_P/e_out_M or timeout
// SPACER   | all rails 0 for SPACER_CYCLES cycles
// RESP     | response offered until rsp_ready
module xor_env_mealy_driver #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SPACER_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_a,
  input  logic req_b,
  output logic req_ready,
  output logic a_P_,
  output logic a_M_,
  output logic b_P_,
  output logic b_M_,
  input  logic e_out_P,
  input  logic e_out_M,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_e,
  output logic rsp_err,
  output logic rsp_timeout
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > SPACER_CYCLES) ? TIMEOUT_CYCLES : SPACER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SP_LAST = CNT_W'(SPACER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_OUT, SPACER, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rails_q, rails_d;
  logic             rsp_e_q, rsp_e_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             pulse;

  assign pulse = e_out_P | e_out_M;

  always_comb begin
    state_d       = state_q;
    rails_d       = rails_q;
    rsp_e_d       = rsp_e_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rails_d = {req_a, ~req_a, req_b, ~req_b};
          state_d = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        // A pulse on the final count still counts as an answer, not a timeout.
        if (pulse) begin
          rsp_e_d       = e_out_P;
          rsp_timeout_d = 1'b0;
`ifdef XOR_ENV_CHECK_EN
          rsp_err_d     = (e_out_P & e_out_M) | (e_out_P != (rails_q[3] ^ rails_q[1]));
`else
          rsp_err_d     = 1'b0;
`endif
          rails_d       = '0;
          state_d       = SPACER;
        end else if (cnt_q == TO_LAST) begin
          rsp_e_d       = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_err_d     = 1'b1;
          rails_d       = '0;
          state_d       = SPACER;
        end
      end
      SPACER: begin
`ifdef XOR_ENV_CHECK_EN
        if (pulse) rsp_err_d = 1'b1;
`endif
        if (cnt_q == SP_LAST) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rails_q       <= '0;
      rsp_e_q       <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rails_q       <= rails_d;
      rsp_e_q       <= rsp_e_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == IDLE) & ~reset;
  assign rsp_valid   = (state_q == RESP);
  assign {a_P_, a_M_, b_P_, b_M_} = rails_q;
  assign rsp_e       = rsp_e_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_xor_env_mealy_driver.sv
// Directed bench for xor_env_mealy_driver; the bench itself plays the xor network.
module tb_xor_env_mealy_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_a = 1'b0, req_b = 1'b0, req_ready;
  logic a_P_, a_M_, b_P_, b_M_;
  logic e_out_P = 1'b0, e_out_M = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_e, rsp_err, rsp_timeout;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef XOR_ENV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  xor_env_mealy_driver #(.TIMEOUT_CYCLES(16), .SPACER_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .a_P_(a_P_), .a_M_(a_M_), .b_P_(b_P_), .b_M_(b_M_),
    .e_out_P(e_out_P), .e_out_M(e_out_M),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_e(rsp_e), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic a, input logic b);
    req_valid = 1'b1; req_a = a; req_b = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse(input logic p, input logic m);
    e_out_P = p; e_out_M = m;
    step();
    e_out_P = 1'b0; e_out_M = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b0000) begin n_fails++; $display("FAIL reset_rails got %b exp 0000", {a_P_, a_M_, b_P_, b_M_}); end
    n_checks++; if ({rsp_valid, rsp_e, rsp_err, rsp_timeout} !== 4'b0000) begin n_fails++; $display("FAIL reset_rsp got %b exp 0000", {rsp_valid, rsp_e, rsp_err, rsp_timeout}); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    accept(1'b1, 1'b0);
    n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("FAIL basic_req_ready got %b exp 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b1001) begin n_fails++; $display("FAIL basic_rails cyc %0d got %b exp 1001", i, {a_P_, a_M_, b_P_, b_M_}); end
      if (i < 2) step();
    end
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if ({a_P_, a_M_, b_P_, b_M_, rsp_valid} !== 5'b00000) begin n_fails++; $display("FAIL basic_spacer cyc %0d got %b exp 00000", i, {a_P_, a_M_, b_P_, b_M_, rsp_valid}); end
      step();
    end
    n_checks++; if ({rsp_valid, rsp_e, rsp_err, rsp_timeout} !== 4'b1100) begin n_fails++; $display("FAIL basic_rsp got %b exp 1100", {rsp_valid, rsp_e, rsp_err, rsp_timeout}); end
    ack();
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fails++; $display("FAIL basic_ack got %b exp 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_all_pairs();
    bit ok;
    logic [1:0] ab;
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      accept(ab[1], ab[0]);
      n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== {ab[1], ~ab[1], ab[0], ~ab[0]}) begin n_fails++; $display("FAIL pair%0d_rails got %b exp %b", k, {a_P_, a_M_, b_P_, b_M_}, {ab[1], ~ab[1], ab[0], ~ab[0]}); end
      step();
      n_checks++; if ((a_P_ & a_M_) | (b_P_ & b_M_)) begin n_fails++; $display("FAIL pair%0d_overlap got %b exp no overlap", k, {a_P_, a_M_, b_P_, b_M_}); end
      pulse(ab[1] ^ ab[0], ~(ab[1] ^ ab[0]));
      wait_rsp(ok);
      n_checks++; if (!ok) begin n_fails++; $display("FAIL pair%0d_rsp_wait got no rsp_valid exp rsp_valid within 20 cycles", k); end
      n_checks++; if ({rsp_e, rsp_err, rsp_timeout} !== {ab[1] ^ ab[0], 2'b00}) begin n_fails++; $display("FAIL pair%0d_result got %b exp %b", k, {rsp_e, rsp_err, rsp_timeout}, {ab[1] ^ ab[0], 2'b00}); end
      ack();
    end
  endtask

  task automatic test_timeout();
    accept(1'b0, 1'b1);
    repeat (15) step();
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b0110) begin n_fails++; $display("FAIL timeout_rails_cyc15 got %b exp 0110", {a_P_, a_M_, b_P_, b_M_}); end
    step();
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_, rsp_valid} !== 5'b00000) begin n_fails++; $display("FAIL timeout_rails_cyc16 got %b exp 00000", {a_P_, a_M_, b_P_, b_M_, rsp_valid}); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL timeout_spacer got %b exp 0", rsp_valid); end
    step();
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin n_fails++; $display("FAIL timeout_rsp got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
    ack();
    n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_fails++; $display("FAIL timeout_clear got %b exp 00", {rsp_err, rsp_timeout}); end
  endtask

  task automatic test_pulse_at_timeout();
    bit ok;
    accept(1'b1, 1'b0);
    repeat (15) step();
    pulse(1'b1, 1'b0);
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b0000) begin n_fails++; $display("FAIL edge_pulse_rails got %b exp 0000", {a_P_, a_M_, b_P_, b_M_}); end
    wait_rsp(ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL edge_pulse_wait got no rsp_valid exp rsp_valid within 20 cycles"); end
    n_checks++; if ({rsp_e, rsp_err, rsp_timeout} !== 3'b100) begin n_fails++; $display("FAIL edge_pulse_rsp got %b exp 100", {rsp_e, rsp_err, rsp_timeout}); end
    ack();
  endtask

  task automatic test_checker();
    bit ok;
    accept(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    wait_rsp(ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL wrong_val_wait got no rsp_valid exp rsp_valid"); end
    n_checks++; if ({rsp_e, rsp_err, rsp_timeout} !== {1'b1, CHK, 1'b0}) begin n_fails++; $display("FAIL wrong_val_rsp got %b exp %b", {rsp_e, rsp_err, rsp_timeout}, {1'b1, CHK, 1'b0}); end
    ack();
    accept(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    wait_rsp(ok);
    n_checks++; if ({rsp_valid, rsp_e, rsp_err, rsp_timeout} !== {2'b11, CHK, 1'b0}) begin n_fails++; $display("FAIL dual_pulse_rsp got %b exp %b", {rsp_valid, rsp_e, rsp_err, rsp_timeout}, {2'b11, CHK, 1'b0}); end
    ack();
    accept(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_rsp(ok);
    n_checks++; if ({rsp_valid, rsp_e, rsp_err, rsp_timeout} !== {2'b11, CHK, 1'b0}) begin n_fails++; $display("FAIL spurious_rsp got %b exp %b", {rsp_valid, rsp_e, rsp_err, rsp_timeout}, {2'b11, CHK, 1'b0}); end
    ack();
  endtask

  task automatic test_back_pressure();
    bit ok;
    accept(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    wait_rsp(ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL bp_wait got no rsp_valid exp rsp_valid"); end
    req_valid = 1'b1; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({req_ready, rsp_valid, rsp_e, rsp_err, rsp_timeout} !== 5'b01000) begin n_fails++; $display("FAIL bp_hold cyc %0d got %b exp 01000", i, {req_ready, rsp_valid, rsp_e, rsp_err, rsp_timeout}); end
      step();
    end
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b0000) begin n_fails++; $display("FAIL bp_no_accept got %b exp 0000", {a_P_, a_M_, b_P_, b_M_}); end
    ack();
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fails++; $display("FAIL bp_idle got %b exp 10", {req_ready, rsp_valid}); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept(1'b1, 1'b0);
    step();
    reset = 1'b1;
    step();
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_, rsp_valid, req_ready} !== 6'b000000) begin n_fails++; $display("FAIL midreset_outs got %b exp 000000", {a_P_, a_M_, b_P_, b_M_, rsp_valid, req_ready}); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL midreset_ready got %b exp 1", req_ready); end
    accept(1'b0, 1'b0);
    n_checks++; if ({a_P_, a_M_, b_P_, b_M_} !== 4'b0101) begin n_fails++; $display("FAIL midreset_fresh got %b exp 0101", {a_P_, a_M_, b_P_, b_M_}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_pairs();
    test_timeout();
    test_pulse_at_timeout();
    test_checker();
    test_back_pressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
